// File: rtl/mapa_pkg.sv
// Shared definitions for the map write front end: cell codes, FSM states,
// requester indices and the coordinate range helper.
package mapa_pkg;

    // Cell codes stored in the map memory
    localparam logic [3:0] NADA      = 4'd0;
    localparam logic [3:0] OBSTACULO = 4'd1;
    localparam logic [3:0] FRUTA     = 4'd2;
    // Snake cells: bit3 = snake, bit2 = snake id, bits1:0 = tail direction
    localparam logic [3:0] COBRA     = 4'd8;

    // Requester slots, also the round-robin order (cobra -> obst -> fruta)
    localparam int COBRA_IDX = 0;
    localparam int OBST_IDX  = 1;
    localparam int FRUTA_IDX = 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_LIMPA = 1'b1
    } estado_t;

    // True when (x, y) lies inside a map of w_lim columns by h_lim rows
    function automatic logic coord_ok(input logic [9:0] x, input logic [9:0] y,
                                      input logic [9:0] w_lim, input logic [9:0] h_lim);
        return (x < w_lim) && (y < h_lim);
    endfunction

endpackage

// File: rtl/mapa_arbitro_rr_arbiter3.sv
// Three-way round-robin arbiter. Grant is combinational from the masked
// request vector; the priority pointer is registered and moves past the
// winner whenever a grant is issued while enabled.
module rr_arbiter3
    import mapa_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] mask,
    input  logic       enable,
    output logic [2:0] grant
);

    logic [1:0] ptr;
    logic [2:0] active;

    assign active = req & ~mask;

    // Pick the first active requester starting at the pointer
    always_comb begin
        grant = 3'b000;
        if (enable) begin
            case (ptr)
                2'd1: begin
                    if (active[1])      grant = 3'b010;
                    else if (active[2]) grant = 3'b100;
                    else if (active[0]) grant = 3'b001;
                end
                2'd2: begin
                    if (active[2])      grant = 3'b100;
                    else if (active[0]) grant = 3'b001;
                    else if (active[1]) grant = 3'b010;
                end
                default: begin
                    if (active[0])      grant = 3'b001;
                    else if (active[1]) grant = 3'b010;
                    else if (active[2]) grant = 3'b100;
                end
            endcase
        end
    end

    // Advance the pointer to the slot after the winner; hold when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 2'(COBRA_IDX);
        end else if (grant[COBRA_IDX]) begin
            ptr <= 2'(OBST_IDX);
        end else if (grant[OBST_IDX]) begin
            ptr <= 2'(FRUTA_IDX);
        end else if (grant[FRUTA_IDX]) begin
            ptr <= 2'(COBRA_IDX);
        end
    end

endmodule

// File: rtl/mapa_arbitro.sv
// Single-writer front end for the game map: round-robin arbitration of the
// snake, fruit and obstacle writers, plus the new-game full-map clear.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | serve requests, one grant per cycle; limpa_start wins over them
//   S_LIMPA | sweep every cell to NADA, x inner loop, then one done cycle
module mapa_arbitro
    import mapa_pkg::*;
#(
    parameter int MAPA_WIDTH  = 32,
    parameter int MAPA_HEIGHT = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       limpa_start,
    output logic       limpa_busy,
    output logic       limpa_done,
    input  logic       cobra_req,
    input  logic       fruta_req,
    input  logic       obst_req,
    input  logic [3:0] cobra_dado,
    input  logic [3:0] fruta_dado,
    input  logic [3:0] obst_dado,
    input  logic [9:0] cobra_x,
    input  logic [9:0] fruta_x,
    input  logic [9:0] obst_x,
    input  logic [9:0] cobra_y,
    input  logic [9:0] fruta_y,
    input  logic [9:0] obst_y,
    output logic       cobra_ack,
    output logic       fruta_ack,
    output logic       obst_ack,
    output logic       coord_err,
    output logic       map_write,
    output logic [3:0] map_dado,
    output logic [9:0] map_x,
    output logic [9:0] map_y
);

    localparam logic [9:0] W_LIM  = 10'(MAPA_WIDTH);
    localparam logic [9:0] H_LIM  = 10'(MAPA_HEIGHT);
    localparam logic [9:0] X_LAST = 10'(MAPA_WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(MAPA_HEIGHT - 1);

    estado_t    estado;
    logic [9:0] cnt_x;
    logic [9:0] cnt_y;
    logic       sweep_fim;

    logic [2:0] req_vec;
    logic [2:0] ack_vec;
    logic [2:0] grant;
    logic       arb_en;

    logic [3:0] sel_dado;
    logic [9:0] sel_x;
    logic [9:0] sel_y;

    assign req_vec[COBRA_IDX] = cobra_req;
    assign req_vec[OBST_IDX]  = obst_req;
    assign req_vec[FRUTA_IDX] = fruta_req;

    // A requester whose ack is high this cycle is still holding its old req
    assign ack_vec[COBRA_IDX] = cobra_ack;
    assign ack_vec[OBST_IDX]  = obst_ack;
    assign ack_vec[FRUTA_IDX] = fruta_ack;

    // Clear request takes the cycle, so the arbiter must not move its pointer
    assign arb_en = (estado == S_IDLE) && !limpa_start;

    rr_arbiter3 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req_vec),
        .mask   (ack_vec),
        .enable (arb_en),
        .grant  (grant)
    );

    // Route the winner's cell value and coordinates
    always_comb begin
        sel_dado = NADA;
        sel_x    = '0;
        sel_y    = '0;
        if (grant[COBRA_IDX]) begin
            sel_dado = cobra_dado;
            sel_x    = cobra_x;
            sel_y    = cobra_y;
        end else if (grant[OBST_IDX]) begin
            sel_dado = obst_dado;
            sel_x    = obst_x;
            sel_y    = obst_y;
        end else if (grant[FRUTA_IDX]) begin
            sel_dado = fruta_dado;
            sel_x    = fruta_x;
            sel_y    = fruta_y;
        end
    end

    // Controller FSM with registered map port, acks and sweep counters
    always_ff @(posedge clk) begin
        if (reset) begin
            estado     <= S_IDLE;
            cnt_x      <= '0;
            cnt_y      <= '0;
            sweep_fim  <= 1'b0;
            limpa_busy <= 1'b0;
            limpa_done <= 1'b0;
            cobra_ack  <= 1'b0;
            fruta_ack  <= 1'b0;
            obst_ack   <= 1'b0;
            coord_err  <= 1'b0;
            map_write  <= 1'b0;
            map_dado   <= '0;
            map_x      <= '0;
            map_y      <= '0;
        end else begin
            limpa_done <= 1'b0;
            cobra_ack  <= 1'b0;
            fruta_ack  <= 1'b0;
            obst_ack   <= 1'b0;
            coord_err  <= 1'b0;
            map_write  <= 1'b0;

            case (estado)
                S_IDLE: begin
                    if (limpa_start) begin
                        estado     <= S_LIMPA;
                        limpa_busy <= 1'b1;
                        cnt_x      <= '0;
                        cnt_y      <= '0;
                        sweep_fim  <= 1'b0;
                    end else if (|grant) begin
                        cobra_ack <= grant[COBRA_IDX];
                        obst_ack  <= grant[OBST_IDX];
                        fruta_ack <= grant[FRUTA_IDX];
                        if (coord_ok(sel_x, sel_y, W_LIM, H_LIM)) begin
                            map_write <= 1'b1;
                            map_dado  <= sel_dado;
                            map_x     <= sel_x;
                            map_y     <= sel_y;
                        end else begin
                            coord_err <= 1'b1;
                        end
                    end
                end

                S_LIMPA: begin
                    if (sweep_fim) begin
                        // Last cell already written: announce and hand back
                        estado     <= S_IDLE;
                        limpa_busy <= 1'b0;
                        limpa_done <= 1'b1;
                        cnt_x      <= '0;
                        cnt_y      <= '0;
                        sweep_fim  <= 1'b0;
                    end else begin
                        map_write <= 1'b1;
                        map_dado  <= NADA;
                        map_x     <= cnt_x;
                        map_y     <= cnt_y;
                        if (cnt_x == X_LAST) begin
                            if (cnt_y == Y_LAST) begin
                                // Counters park on the last cell until the done cycle
                                sweep_fim <= 1'b1;
                            end else begin
                                cnt_x <= '0;
                                cnt_y <= cnt_y + 10'd1;
                            end
                        end else begin
                            cnt_x <= cnt_x + 10'd1;
                        end
                    end
                end

                default: begin
                    estado     <= S_IDLE;
                    limpa_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mapa_arbitro.sv
// Scoreboard bench for mapa_arbitro: a cycle-level reference model predicts
// each output event and the busy flag, a negedge monitor compares them.
module tb_mapa_arbitro;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       limpa_start;
    logic       limpa_busy, limpa_done;
    logic       cobra_req, fruta_req, obst_req;
    logic [3:0] cobra_dado, fruta_dado, obst_dado;
    logic [9:0] cobra_x, fruta_x, obst_x;
    logic [9:0] cobra_y, fruta_y, obst_y;
    logic       cobra_ack, fruta_ack, obst_ack;
    logic       coord_err, map_write;
    logic [3:0] map_dado;
    logic [9:0] map_x, map_y;

    // Requester slots: 0 = cobra, 1 = obst, 2 = fruta
    logic       r_req [3];
    logic [3:0] r_dado[3];
    logic [9:0] r_x   [3];
    logic [9:0] r_y   [3];

    assign cobra_req  = r_req[0];  assign cobra_dado = r_dado[0];
    assign cobra_x    = r_x[0];    assign cobra_y    = r_y[0];
    assign obst_req   = r_req[1];  assign obst_dado  = r_dado[1];
    assign obst_x     = r_x[1];    assign obst_y     = r_y[1];
    assign fruta_req  = r_req[2];  assign fruta_dado = r_dado[2];
    assign fruta_x    = r_x[2];    assign fruta_y    = r_y[2];

    mapa_arbitro #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .limpa_start(limpa_start),
        .limpa_busy(limpa_busy), .limpa_done(limpa_done),
        .cobra_req(cobra_req), .fruta_req(fruta_req), .obst_req(obst_req),
        .cobra_dado(cobra_dado), .fruta_dado(fruta_dado), .obst_dado(obst_dado),
        .cobra_x(cobra_x), .fruta_x(fruta_x), .obst_x(obst_x),
        .cobra_y(cobra_y), .fruta_y(fruta_y), .obst_y(obst_y),
        .cobra_ack(cobra_ack), .fruta_ack(fruta_ack), .obst_ack(obst_ack),
        .coord_err(coord_err), .map_write(map_write),
        .map_dado(map_dado), .map_x(map_x), .map_y(map_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       wr;
        logic [3:0] dado;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] acks;
        logic       err;
        logic       done;
    } ev_t;

    typedef struct {
        int   cyc;
        logic busy;
    } busy_t;

    ev_t   exp_q[$];
    busy_t busy_q[$];
    int    checks  = 0;
    int    errors  = 0;
    int    cyc_cnt = 0;

    // Reference model: linear sweep index, integer pointer, clear flag
    int         m_ptr   = 0;
    bit         m_limpa = 0;
    int         m_k     = 0;
    logic [2:0] m_ack   = 3'b000;

    task automatic predict();
        ev_t   e;
        busy_t b;
        bit    has = 0;
        int    win = -1;
        e.cyc = cyc_cnt + 1; e.wr = 0; e.dado = 0; e.x = 0; e.y = 0;
        e.acks = 0; e.err = 0; e.done = 0;
        if (reset) begin
            m_ptr = 0; m_limpa = 0; m_k = 0; m_ack = 0;
        end else if (m_limpa) begin
            if (m_k == W * H) begin
                e.done = 1; has = 1; m_limpa = 0; m_k = 0;
            end else begin
                e.wr = 1; e.dado = 0; e.x = 10'(m_k % W); e.y = 10'(m_k / W);
                has = 1; m_k++;
            end
            m_ack = 0;
        end else if (limpa_start) begin
            m_limpa = 1; m_k = 0; m_ack = 0;
        end else begin
            for (int s = 0; s < 3; s++) begin
                int i;
                i = (m_ptr + s) % 3;
                if (win < 0 && r_req[i] && !m_ack[i]) win = i;
            end
            m_ack = 0;
            if (win >= 0) begin
                has = 1;
                e.acks[win] = 1'b1;
                m_ack[win]  = 1'b1;
                if (r_x[win] >= W || r_y[win] >= H) begin
                    e.err = 1;
                end else begin
                    e.wr = 1; e.dado = r_dado[win]; e.x = r_x[win]; e.y = r_y[win];
                end
                m_ptr = (win + 1) % 3;
            end
        end
        if (has) exp_q.push_back(e);
        b.cyc = cyc_cnt + 1; b.busy = m_limpa;
        busy_q.push_back(b);
    endtask

    task automatic rand_data(input int i);
        r_dado[i] = 4'($urandom_range(0, 15));
        r_x[i]    = ($urandom_range(0, 19) == 0) ? 10'd1023 : 10'($urandom_range(0, W + 1));
        r_y[i]    = 10'($urandom_range(0, H + 1));
    endtask

    // Requesters react to the ack of the edge just passed
    task automatic update_reqs(input bit hold, input int p_raise);
        for (int i = 0; i < 3; i++) begin
            if (m_ack[i]) begin
                if (!hold) begin
                    if ($urandom_range(0, 1) == 0) r_req[i] = 1'b0;
                    else rand_data(i);
                end
            end else if (!r_req[i] && int'($urandom_range(0, 99)) < p_raise) begin
                r_req[i] = 1'b1;
                rand_data(i);
            end
        end
    endtask

    task automatic cycle();
        predict();
        @(posedge clk);
        cyc_cnt++;
        #2;
    endtask

    task automatic run(input int n, input bit hold, input int p_raise);
        for (int c = 0; c < n; c++) begin
            update_reqs(hold, p_raise);
            cycle();
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] d, input logic [9:0] x, input logic [9:0] y);
        r_req[i] = 1'b1; r_dado[i] = d; r_x[i] = x; r_y[i] = y;
    endtask

    task automatic check_bit(input string name, input logic act, input logic req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, act, req_v);
        end
    endtask

    // Monitor: compare DUT events and busy flag against the scoreboard
    always @(negedge clk) begin
        ev_t        e;
        logic [2:0] acks;
        bit         present;
        acks    = {fruta_ack, obst_ack, cobra_ack};
        present = map_write || (|acks) || coord_err || limpa_done;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
            e = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL missing_event cyc=%0d: got nothing want wr=%0b acks=%b err=%0b done=%0b",
                     e.cyc, e.wr, e.acks, e.err, e.done);
        end
        if (present) begin
            checks++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
                e = exp_q.pop_front();
                if (map_write !== e.wr || acks !== e.acks || coord_err !== e.err ||
                    limpa_done !== e.done ||
                    (e.wr && (map_dado !== e.dado || map_x !== e.x || map_y !== e.y))) begin
                    errors++;
                    $display("FAIL event cyc=%0d: got wr=%0b d=%0d x=%0d y=%0d acks=%b err=%0b done=%0b want wr=%0b d=%0d x=%0d y=%0d acks=%b err=%0b done=%0b",
                             cyc_cnt, map_write, map_dado, map_x, map_y, acks, coord_err, limpa_done,
                             e.wr, e.dado, e.x, e.y, e.acks, e.err, e.done);
                end
            end else begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d: got wr=%0b acks=%b err=%0b done=%0b want none",
                         cyc_cnt, map_write, acks, coord_err, limpa_done);
            end
        end
        if (busy_q.size() > 0 && busy_q[0].cyc == cyc_cnt) begin
            busy_t b;
            b = busy_q.pop_front();
            checks++;
            if (limpa_busy !== b.busy) begin
                errors++;
                $display("FAIL limpa_busy cyc=%0d: got %0b want %0b", cyc_cnt, limpa_busy, b.busy);
            end
        end
    end

    initial begin
        reset = 1'b1;
        limpa_start = 1'b0;
        for (int i = 0; i < 3; i++) set_req(i, 4'd0, 10'd0, 10'd0);
        for (int i = 0; i < 3; i++) r_req[i] = 1'b0;
        cycle(); cycle();
        reset = 1'b0;

        check_bit("reset_map_write", map_write, 1'b0);
        check_bit("reset_acks", cobra_ack | obst_ack | fruta_ack, 1'b0);
        check_bit("reset_coord_err", coord_err, 1'b0);
        check_bit("reset_busy_done", limpa_busy | limpa_done, 1'b0);
        check_bit("reset_map_regs", (map_dado == 0) && (map_x == 0) && (map_y == 0), 1'b1);

        // Single cobra request
        set_req(0, 4'b1000, 10'd5, 10'd3);
        cycle();
        r_req[0] = 1'b0;
        run(3, 0, 0);

        // Contention from a fresh pointer: all three held for six cycles
        reset = 1'b1; cycle(); reset = 1'b0;
        set_req(0, 4'd8, 10'd1, 10'd1);
        set_req(1, 4'd1, 10'd2, 10'd2);
        set_req(2, 4'd2, 10'd3, 10'd3);
        run(6, 1, 0);
        for (int i = 0; i < 3; i++) r_req[i] = 1'b0;
        run(2, 0, 0);

        // Clear with a fruit request arriving mid-sweep
        limpa_start = 1'b1; cycle(); limpa_start = 1'b0;
        run(10, 0, 0);
        set_req(2, 4'd2, 10'd4, 10'd4);
        limpa_start = 1'b1; cycle(); limpa_start = 1'b0;
        run(W * H, 0, 0);
        for (int i = 0; i < 3; i++) r_req[i] = 1'b0;
        run(2, 0, 0);

        // Out-of-range obstacle write, fruit waiting behind it
        reset = 1'b1; cycle(); reset = 1'b0;
        set_req(1, 4'd1, 10'(W), 10'd0);
        set_req(2, 4'd2, 10'd6, 10'(H - 1));
        run(4, 0, 0);
        for (int i = 0; i < 3; i++) r_req[i] = 1'b0;
        run(2, 0, 0);

        // Reset in the middle of a sweep, then full contention
        limpa_start = 1'b1; cycle(); limpa_start = 1'b0;
        run(5, 0, 0);
        reset = 1'b1; cycle(); reset = 1'b0;
        set_req(0, 4'd9, 10'd0, 10'd0);
        set_req(1, 4'd1, 10'd1, 10'd0);
        set_req(2, 4'd2, 10'd2, 10'd0);
        run(4, 1, 0);
        for (int i = 0; i < 3; i++) r_req[i] = 1'b0;
        run(2, 0, 0);

        // Clear start and cobra request in the same cycle
        set_req(0, 4'd12, 10'd7, 10'd5);
        limpa_start = 1'b1; cycle(); limpa_start = 1'b0;
        run(W * H + 4, 0, 0);
        for (int i = 0; i < 3; i++) r_req[i] = 1'b0;
        run(2, 0, 0);

        // Randomized traffic with occasional clears and resets
        for (int c = 0; c < 3000; c++) begin
            limpa_start = ($urandom_range(0, 149) == 0);
            reset       = ($urandom_range(0, 399) == 0);
            update_reqs(0, 30);
            cycle();
        end
        reset = 1'b0; limpa_start = 1'b0;
        for (int i = 0; i < 3; i++) r_req[i] = 1'b0;
        run(W * H + 6, 0, 0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending events want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
